// File: rtl/vga_frame_monitor_if.sv
// rtl/vga_frame_monitor_if.sv - VGA pins into the frame monitor and its measured results back out.
interface vga_frame_monitor_if;
   logic        hsync;
   logic        vsync;
   logic [2:0]  red;
   logic [2:0]  green;
   logic [1:0]  blue;
   logic        locked;
   logic [10:0] h_period;
   logic [9:0]  v_lines;
   logic [15:0] checksum;
   logic [18:0] pixel_count;
   logic        frame_done;
   logic [7:0]  err_count;

   modport master (
      output hsync, vsync, red, green, blue,
      input  locked, h_period, v_lines, checksum, pixel_count, frame_done, err_count
   );

   modport slave (
      input  hsync, vsync, red, green, blue,
      output locked, h_period, v_lines, checksum, pixel_count, frame_done, err_count
   );
endinterface

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - recovers VGA line/frame timing, checks it against the expected mode
// and reports measured geometry plus a visible-area checksum per frame.
module vga_frame_monitor #(
   parameter int H_TOTAL         = 800,
   parameter int H_START         = 144,
   parameter int H_VISIBLE       = 640,
   parameter int V_TOTAL         = 525,
   parameter int V_START         = 35,
   parameter int V_VISIBLE       = 480,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input logic                i_clk,
   input logic                i_reset,
   vga_frame_monitor_if.slave bus
);

   typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

   localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
   localparam logic [10:0] H_MAX     = 11'h7FF;
   localparam logic [9:0]  V_MAX     = 10'h3FF;
   localparam logic [11:0] H_TOT     = 12'(H_TOTAL);
   localparam logic [11:0] H_LO      = 12'(H_START);
   localparam logic [11:0] H_HI      = 12'(H_START + H_VISIBLE);
   localparam logic [9:0]  V_TOT     = 10'(V_TOTAL);
   localparam logic [10:0] V_LO      = 11'(V_START);
   localparam logic [10:0] V_HI      = 11'(V_START + V_VISIBLE);

   state_t      state;
   logic        hs_r, hs_d, vs_r, vs_d;
   logic [7:0]  pix_r;
   logic [10:0] h_cnt;
   logic        h_valid;
   logic [9:0]  v_cnt;
   logic [15:0] sum;
   logic [18:0] pix_cnt;
   logic        line_err;

   logic        locked_r;
   logic [10:0] h_period_r;
   logic [9:0]  v_lines_r;
   logic [15:0] checksum_r;
   logic [18:0] pixel_count_r;
   logic        frame_done_r;
   logic [7:0]  err_cnt;

   logic        hs_edge, vs_edge;
   logic [10:0] h_pos;
   logic [9:0]  v_pos;
   logic [9:0]  line_idx;
   logic [11:0] period;
   logic        period_bad;
   logic        timeout;
   logic        in_win;
   logic [15:0] pix_val;
   logic        frame_ok;
   logic        lines_bad;

   // h_pos/v_pos describe the pixel currently in pix_r; the edge cycle itself is position 0.
   always_comb begin
      hs_edge    = (hs_r != SYNC_IDLE) && (hs_d == SYNC_IDLE);
      vs_edge    = (vs_r != SYNC_IDLE) && (vs_d == SYNC_IDLE);
      h_pos      = hs_edge ? 11'd0 : ((h_cnt == H_MAX) ? H_MAX : h_cnt + 11'd1);
      period     = {1'b0, h_cnt} + 12'd1;
      period_bad = hs_edge && h_valid && (period != H_TOT);
      timeout    = (h_pos == H_MAX);

      v_pos = v_cnt;
      if (vs_edge)
         v_pos = hs_edge ? 10'd1 : 10'd0;
      else if (hs_edge && (v_cnt != V_MAX))
         v_pos = v_cnt + 10'd1;
      line_idx = v_pos - 10'd1;

      in_win  = ({1'b0, h_pos} >= H_LO) && ({1'b0, h_pos} < H_HI) &&
                ({1'b0, line_idx} >= V_LO) && ({1'b0, line_idx} < V_HI);
      pix_val = in_win ? {8'd0, pix_r} : 16'd0;

      // v_cnt still holds the line count of the frame being closed.
      lines_bad = (v_cnt != V_TOT);
      frame_ok  = !line_err && !period_bad && !lines_bad;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= S_SEARCH;
         hs_r          <= SYNC_IDLE;
         hs_d          <= SYNC_IDLE;
         vs_r          <= SYNC_IDLE;
         vs_d          <= SYNC_IDLE;
         pix_r         <= 8'd0;
         h_cnt         <= 11'd0;
         h_valid       <= 1'b0;
         v_cnt         <= 10'd0;
         sum           <= 16'd0;
         pix_cnt       <= 19'd0;
         line_err      <= 1'b0;
         locked_r      <= 1'b0;
         h_period_r    <= 11'd0;
         v_lines_r     <= 10'd0;
         checksum_r    <= 16'd0;
         pixel_count_r <= 19'd0;
         frame_done_r  <= 1'b0;
         err_cnt       <= 8'd0;
      end else begin
         hs_r  <= bus.hsync;
         hs_d  <= hs_r;
         vs_r  <= bus.vsync;
         vs_d  <= vs_r;
         pix_r <= {bus.red, bus.green, bus.blue};

         h_cnt <= h_pos;
         v_cnt <= v_pos;
         if (hs_edge)
            h_valid <= 1'b1;
         else if (timeout)
            h_valid <= 1'b0;
         if (hs_edge && h_valid)
            h_period_r <= period[10:0];

         if (vs_edge) begin
            v_lines_r     <= v_cnt;
            checksum_r    <= sum;
            pixel_count_r <= pix_cnt;
            sum           <= pix_val;
            pix_cnt       <= {18'd0, in_win};
            line_err      <= 1'b0;
         end else begin
            sum     <= sum + pix_val;
            pix_cnt <= pix_cnt + {18'd0, in_win};
            if (period_bad)
               line_err <= 1'b1;
         end

         frame_done_r <= 1'b0;
         if (timeout) begin
            if (state == S_LOCKED && err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
            state    <= S_SEARCH;
            locked_r <= 1'b0;
         end else begin
            case (state)
               S_SEARCH: begin
                  if (vs_edge)
                     state <= S_MEASURE;
               end
               S_MEASURE: begin
                  if (vs_edge && frame_ok) begin
                     state    <= S_LOCKED;
                     locked_r <= 1'b1;
                  end
               end
               S_LOCKED: begin
                  // A bad period landing on the VSYNC edge still counts once.
                  if (period_bad || (vs_edge && lines_bad)) begin
                     if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                     state    <= S_MEASURE;
                     locked_r <= 1'b0;
                  end else if (vs_edge) begin
                     frame_done_r <= 1'b1;
                  end
               end
               default: begin
                  state    <= S_SEARCH;
                  locked_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.locked      = locked_r;
   assign bus.h_period    = h_period_r;
   assign bus.v_lines     = v_lines_r;
   assign bus.checksum    = checksum_r;
   assign bus.pixel_count = pixel_count_r;
   assign bus.frame_done  = frame_done_r;
   assign bus.err_count   = err_cnt;

endmodule
